// File: rtl/mem_bus_pkg.sv
// Shared memory-bus types and field widths for the bus masters and the
// arbiter that multiplexes them onto the single slave port.
package mem_bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int BE_W   = 4;
  localparam int NUM_M  = 2;

  typedef logic master_id_t;

  localparam master_id_t MASTER_CPU = 1'b0;
  localparam master_id_t MASTER_AUX = 1'b1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic [BE_W-1:0]   byte_enable;
    logic              write_req;
    logic              read_req;
  } bus_req_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order FIFO of master IDs for reads accepted by the slave; the head
// names the master that owns the next returning read response.
module tag_fifo
  import mem_bus_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  master_id_t               din,
  input  logic                     pop,
  output master_id_t               head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  master_id_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic            push_ok, pop_ok;

  assign pop_ok  = pop & (count != '0);
  // A full FIFO still takes a push when a pop frees the slot in the same cycle.
  assign push_ok = push & ((count != CW'(DEPTH)) | pop_ok);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push_ok) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin arbiter onto one memory bus. A stalled grant is
// locked until accepted; read ownership is tracked in an in-order tag FIFO.
module mem_arbiter
  import mem_bus_pkg::*;
#(
  parameter int TAG_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [ADDR_W-1:0]          m0_addr,
  input  logic [DATA_W-1:0]          m0_write_data,
  input  logic [BE_W-1:0]            m0_byte_enable,
  input  logic                       m0_write_req,
  input  logic                       m0_read_req,
  output logic                       m0_ready,
  output logic [DATA_W-1:0]          m0_read_data,
  output logic                       m0_read_data_valid,
  input  logic [ADDR_W-1:0]          m1_addr,
  input  logic [DATA_W-1:0]          m1_write_data,
  input  logic [BE_W-1:0]            m1_byte_enable,
  input  logic                       m1_write_req,
  input  logic                       m1_read_req,
  output logic                       m1_ready,
  output logic [DATA_W-1:0]          m1_read_data,
  output logic                       m1_read_data_valid,
  output logic [ADDR_W-1:0]          s_addr,
  output logic [DATA_W-1:0]          s_write_data,
  output logic [BE_W-1:0]            s_byte_enable,
  output logic                       s_write_req,
  output logic                       s_read_req,
  input  logic                       s_ready,
  input  logic [DATA_W-1:0]          s_read_data,
  input  logic                       s_read_data_valid,
  output logic [$clog2(TAG_DEPTH):0] outstanding,
  output logic                       protocol_error
);

  localparam int CW = $clog2(TAG_DEPTH) + 1;

  bus_req_t [NUM_M-1:0] req;
  bus_req_t             sel;
  logic [NUM_M-1:0]     req_any, ready, rvalid;
  master_id_t           grant, last, lock_id, head;
  logic                 granted, lock_valid, pending, accept, pop;
  logic [CW-1:0]        count;

  assign req[MASTER_CPU] = '{addr: m0_addr, write_data: m0_write_data,
                             byte_enable: m0_byte_enable,
                             write_req: m0_write_req, read_req: m0_read_req};
  assign req[MASTER_AUX] = '{addr: m1_addr, write_data: m1_write_data,
                             byte_enable: m1_byte_enable,
                             write_req: m1_write_req, read_req: m1_read_req};

  for (genvar i = 0; i < NUM_M; i++) begin : g_req
    assign req_any[i] = req[i].write_req | req[i].read_req;
  end

  always_comb begin
    grant   = MASTER_CPU;
    granted = 1'b0;
    if (lock_valid) begin
      grant   = lock_id;
      granted = 1'b1;
    end else if (req_any == 2'b11) begin
      grant   = ~last;
      granted = 1'b1;
    end else if (req_any != 2'b00) begin
      grant   = req_any[MASTER_AUX] ? MASTER_AUX : MASTER_CPU;
      granted = 1'b1;
    end
  end

  assign sel           = req[grant];
  assign s_addr        = sel.addr;
  assign s_write_data  = sel.write_data;
  assign s_byte_enable = sel.byte_enable;
  assign s_write_req   = granted & sel.write_req;
  // Writes win over a simultaneous read strobe; reads also need a free tag slot.
  assign s_read_req    = granted & sel.read_req & ~sel.write_req & (count < CW'(TAG_DEPTH));
  assign accept        = (s_write_req | s_read_req) & s_ready;
  assign pending       = granted & (sel.write_req | sel.read_req);
  assign pop           = s_read_data_valid & (count != '0);

  for (genvar i = 0; i < NUM_M; i++) begin : g_resp
    assign ready[i]  = accept & (grant == master_id_t'(i));
    assign rvalid[i] = pop & (head == master_id_t'(i));
  end

  assign m0_ready           = ready[MASTER_CPU];
  assign m1_ready           = ready[MASTER_AUX];
  assign m0_read_data_valid = rvalid[MASTER_CPU];
  assign m1_read_data_valid = rvalid[MASTER_AUX];
  assign m0_read_data       = s_read_data;
  assign m1_read_data       = s_read_data;
  assign outstanding        = count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_valid     <= 1'b0;
      lock_id        <= MASTER_CPU;
      last           <= MASTER_AUX;
      protocol_error <= 1'b0;
    end else begin
      if (accept) begin
        lock_valid <= 1'b0;
        last       <= grant;
      end else if (pending) begin
        lock_valid <= 1'b1;
        lock_id    <= grant;
      end
      if (s_read_data_valid && count == '0) protocol_error <= 1'b1;
    end
  end

  tag_fifo #(.DEPTH(TAG_DEPTH)) u_tags (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (accept & s_read_req),
    .din     (grant),
    .pop     (pop),
    .head    (head),
    .count   (count)
  );

endmodule
